// File: rtl/johnson_phase_decoder_5bit.sv
// Decodes a 5-bit Johnson counter state into a phase index and one-hot vector,
// flags illegal codes and out-of-order phases, and counts ring revolutions.
module johnson_phase_decoder_5bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [4:0]       q_in,
  input  logic             clr_err,
  output logic [3:0]       phase_idx,
  output logic [9:0]       phase_onehot,
  output logic             valid,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             wrap,
  output logic [CNT_W-1:0] wrap_count
);

  logic       legal;
  logic [3:0] k;
  logic [3:0] next_idx;

  always_comb begin
    legal = 1'b1;
    k     = 4'd0;
    case (q_in)
      5'b10000: k = 4'd0;
      5'b00000: k = 4'd1;
      5'b00001: k = 4'd2;
      5'b00011: k = 4'd3;
      5'b00111: k = 4'd4;
      5'b01111: k = 4'd5;
      5'b11111: k = 4'd6;
      5'b11110: k = 4'd7;
      5'b11100: k = 4'd8;
      5'b11000: k = 4'd9;
      default:  legal = 1'b0;
    endcase
  end

  assign next_idx = (phase_idx == 4'd9) ? 4'd0 : phase_idx + 4'd1;

  // valid/phase_idx double as the previous-sample state; an invalid previous
  // sample lets the next legal code resynchronise without a sequence error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_idx    <= 4'd0;
      phase_onehot <= 10'd0;
      valid        <= 1'b0;
      err_illegal  <= 1'b0;
      err_seq      <= 1'b0;
      wrap         <= 1'b0;
      wrap_count   <= '0;
    end else begin
      wrap <= 1'b0;
      if (clr_err) begin
        err_illegal <= 1'b0;
        err_seq     <= 1'b0;
      end
      if (en) begin
        if (legal) begin
          phase_idx    <= k;
          phase_onehot <= 10'd1 << k;
          valid        <= 1'b1;
          if (valid && (k != phase_idx) && (k != next_idx))
            err_seq <= 1'b1;
          if (valid && (phase_idx == 4'd9) && (k == 4'd0)) begin
            wrap <= 1'b1;
            if (wrap_count != {CNT_W{1'b1}})
              wrap_count <= wrap_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          valid        <= 1'b0;
          phase_onehot <= 10'd0;
          err_illegal  <= 1'b1;
        end
      end
    end
  end

endmodule
